bram_dram_responder: RTL
========================

Name: bram_dram_responder

Overview:
- Synthesizable, BRAM-backed responder for the DDR3 command/data interface that the ORAM backend drives toward DRAM.
- Accepts read and write commands and masked write beats, and returns read data in command order with a bounded, configurable latency.
- Used in simulation and FPGA bring-up in place of the MIG/DDR3 controller.
- Sits directly on the wide DDRDWidth side of the shifter FIFOs.

Parameters:
- AWidth, 28: DDR command address width (DDRAWidth).
- DWidth, 512: data beat width (DDRDWidth).
- MWidth, DWidth/8: byte-mask width (DDRMWidth).
- CWidth, 3: command width (DDRCWidth).
- AddrLSB, 3: low address bits dropped. One beat covers 2^AddrLSB DDR addresses.
- MemAWidth, 10: log2 of the number of beats stored. Higher address bits alias (modulo).
- ReadLatency, 2: cycles from read-command acceptance to data entering the output buffer. Must be ≥1.
- OutBufDepth, 4: output buffer entries. Also the maximum number of outstanding reads.

Ports:
- Clock, in, 1: single clock.
- Reset, in, 1: synchronous, active-high.
- CommandAddress, in, AWidth: command address.
- Command, in, CWidth: 3'b000 = write (DDR3CMD_Write), 3'b001 = read (DDR3CMD_Read).
- CommandValid, in, 1: command handshake valid.
- CommandReady, out, 1: command handshake ready.
- DataIn, in, DWidth: write beat.
- DataInMask, in, MWidth: bit i = 1 means byte i is NOT written.
- DataInValid, in, 1: write beat valid.
- DataInReady, out, 1: write beat ready.
- DataOut, out, DWidth: read beat.
- DataOutValid, out, 1: read beat valid.
- DataOutReady, in, 1: read beat ready.

Behaviour:
- Reset:
  - All outputs are 0 during and one cycle after Reset: CommandReady, DataInReady, DataOutValid, DataOut.
  - FSM returns to ST_Idle. Read pipeline, output buffer and credit counter are cleared.
  - Memory contents are preserved (zero at configuration, never cleared by Reset).
- Reset mid-operation: in-flight reads and any pending write are discarded with no memory update. No read data is emitted for pre-reset commands.
- FSM states:
  - ST_Idle: CommandReady = 1 iff Credits < OutBufDepth.
    - Read accepted: issue BRAM read of CommandAddress[AddrLSB +: MemAWidth], Credits += 1, stay in ST_Idle. Back-to-back reads run one per cycle.
    - Write accepted: latch the address and go to ST_WData.
    - Any other Command value: accepted and dropped, no data, stay in ST_Idle.
  - ST_WData: CommandReady = 0, DataInReady = 1.
    - On DataInValid, write the unmasked bytes of DataIn at the latched address in that cycle, then return to ST_Idle.
    - DataInReady is 0 in every other state. Write beats are never buffered ahead of their command.
- Ordering: commands complete strictly in acceptance order. A read accepted after a write to the same beat returns the new data; the write is committed before the next command can be accepted.
- Read pipeline: ReadLatency-stage valid/data shift register feeding an OutBufDepth FIFO.
  - Command accepted at cycle T gives DataOutValid = 1 at T + ReadLatency when the buffer is empty.
- Output handshake:
  - DataOut is held stable while DataOutValid = 1 and DataOutReady = 0.
  - A beat pops when DataOutValid & DataOutReady.
- Credits (0..OutBufDepth, width clog2(OutBufDepth + 1)):
  - Increment on read accept, decrement on pop.
  - On a simultaneous accept and pop, Credits is unchanged and the read is allowed even if Credits == OutBufDepth at cycle start.
  - The FIFO can never overflow. A bench assertion fires if a pipeline beat arrives while the FIFO is full.
- Full/empty:
  - With OutBufDepth reads outstanding and DataOutReady = 0, CommandReady = 0. This also blocks writes, preserving order.
  - When the FIFO is empty, DataOutValid = 0 and DataOut holds its last value.
- Wrap-around: address bits above AddrLSB + MemAWidth are ignored. Address 0 and address 2^(AddrLSB + MemAWidth) hit the same beat.

Test Plan:
- Write 0xA5..A5 to addr 0x40 with mask 0, then read 0x40 → one beat 0xA5..A5. DataOutValid exactly ReadLatency cycles after read accept.
- Write all-ones to 0x80; write zeros to 0x80 with mask = 0xFFFF_FFFF_FFFF_FFFE → readback is 0xFF..FF00 (only byte 0 cleared).
- DataOutReady = 0; issue 6 back-to-back reads of distinct addresses → exactly 4 accepted, CommandReady = 0. Raise DataOutReady → all 6 beats return in issue order, one per cycle once streaming.
- Write command accepted, DataInValid held 0 for 10 cycles → CommandReady stays 0. A later beat is accepted and written. A following read returns the new data.
- Reset asserted while 3 reads are in flight → no DataOutValid after Reset deasserts, Credits = 0, CommandReady = 1 one cycle after reset. Earlier written data is still readable.
- Write 0x1234 at address 0, read address 2^(AddrLSB + MemAWidth) → returns 0x1234. Command 3'b111 → accepted, no data returned.

Source files
------------

// File: rtl/bram_dram_responder.sv
// BRAM-backed DDR3 command/data responder; reads return in order ReadLatency cycles after accept.
// Backpressure: CommandReady drops when OutBufDepth reads are outstanding; DataOut holds while not ready.
module bram_dram_responder #(
    parameter int AWidth      = 28,
    parameter int DWidth      = 512,
    parameter int MWidth      = DWidth / 8,
    parameter int CWidth      = 3,
    parameter int AddrLSB     = 3,
    parameter int MemAWidth   = 10,
    parameter int ReadLatency = 2,
    parameter int OutBufDepth = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [AWidth-1:0] CommandAddress,
    input  logic [CWidth-1:0] Command,
    input  logic              CommandValid,
    output logic              CommandReady,
    input  logic [DWidth-1:0] DataIn,
    input  logic [MWidth-1:0] DataInMask,
    input  logic              DataInValid,
    output logic              DataInReady,
    output logic [DWidth-1:0] DataOut,
    output logic              DataOutValid,
    input  logic              DataOutReady
);
    localparam int CntW = $clog2(OutBufDepth + 1);
    localparam int PtrW = (OutBufDepth > 1) ? $clog2(OutBufDepth) : 1;
    localparam logic [CntW-1:0]   DepthC   = CntW'(OutBufDepth);
    localparam logic [CWidth-1:0] CmdWrite = CWidth'(0);
    localparam logic [CWidth-1:0] CmdRead  = CWidth'(1);

    typedef enum logic {ST_Idle, ST_WData} state_t;

    state_t                state;
    logic                  live;
    logic [MemAWidth-1:0]  wAddr;
    logic [CntW-1:0]       credits;
    logic [CntW-1:0]       count;
    logic [PtrW-1:0]       wrPtr;
    logic [PtrW-1:0]       rdPtr;
    logic [DWidth-1:0]     lastOut;
    logic [DWidth-1:0]     mem [2**MemAWidth];
    logic [DWidth-1:0]     fifoMem [OutBufDepth];

    logic                  pop;
    logic                  cmdFire;
    logic                  readFire;
    logic                  beatFire;
    logic                  pushV;
    logic [DWidth-1:0]     pushD;
    logic [MemAWidth-1:0]  cmdAddr;
    logic                  unusedAddrBits;

    // Bits outside the stored window alias onto the same beat.
    assign cmdAddr        = CommandAddress[AddrLSB +: MemAWidth];
    assign unusedAddrBits = ^{CommandAddress[AddrLSB-1:0], CommandAddress[AWidth-1:AddrLSB+MemAWidth]};

    assign DataOutValid = (count != '0);
    assign DataOut      = DataOutValid ? fifoMem[rdPtr] : lastOut;
    assign pop          = DataOutValid && DataOutReady;
    // A pop in the same cycle frees the slot the new read will need.
    assign CommandReady = !Reset && live && (state == ST_Idle) && ((credits < DepthC) || pop);
    assign DataInReady  = !Reset && live && (state == ST_WData);
    assign cmdFire      = CommandValid && CommandReady;
    assign readFire     = cmdFire && (Command == CmdRead);
    assign beatFire     = DataInValid && DataInReady;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(OutBufDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_Idle;
            live    <= 1'b0;
            wAddr   <= '0;
            credits <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                ST_Idle: begin
                    if (cmdFire && (Command == CmdWrite)) begin
                        wAddr <= cmdAddr;
                        state <= ST_WData;
                    end
                end
                ST_WData: begin
                    if (beatFire) begin
                        state <= ST_Idle;
                    end
                end
            endcase
            if (readFire && !pop) begin
                credits <= credits + 1'b1;
            end else if (!readFire && pop) begin
                credits <= credits - 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (beatFire) begin
            for (int i = 0; i < MWidth; i++) begin
                if (!DataInMask[i]) begin
                    mem[wAddr][i*8 +: 8] <= DataIn[i*8 +: 8];
                end
            end
        end
    end

    generate
        if (ReadLatency == 1) begin : gDirect
            assign pushV = readFire;
            assign pushD = mem[cmdAddr];
        end else begin : gPipe
            logic [ReadLatency-2:0] pipeV;
            logic [DWidth-1:0]      pipeD [ReadLatency-1];

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    pipeV <= '0;
                end else begin
                    pipeV[0] <= readFire;
                    for (int k = 1; k < ReadLatency - 1; k++) begin
                        pipeV[k] <= pipeV[k-1];
                    end
                end
            end

            always_ff @(posedge Clock) begin
                pipeD[0] <= mem[cmdAddr];
                for (int k = 1; k < ReadLatency - 1; k++) begin
                    pipeD[k] <= pipeD[k-1];
                end
            end

            assign pushV = pipeV[ReadLatency-2];
            assign pushD = pipeD[ReadLatency-2];
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (pushV && !Reset) begin
            fifoMem[wrPtr] <= pushD;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            lastOut <= '0;
        end else begin
            if (pushV) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (pop) begin
                lastOut <= fifoMem[rdPtr];
                rdPtr   <= nextPtr(rdPtr);
            end
            if (pushV && !pop) begin
                count <= count + 1'b1;
            end else if (!pushV && pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
